// File: rtl/traffic_light_ctrl.sv
// Traffic-light phase controller driven by the divider's 1 Hz / 4 Hz references.
// Sequences vehicle and walk lamps with pedestrian green-cut and blinking night mode.
module traffic_light_ctrl #(
  parameter int GREEN_S   = 10,
  parameter int YELLOW_S  = 3,
  parameter int RED_S     = 8,
  parameter int WALK_S    = 6,
  parameter int PED_CUT_S = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       clk_4hz,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic       walk,
  output logic [2:0] phase,
  output logic [7:0] sec_left,
  output logic       ped_pending
);

  typedef enum logic [2:0] {
    S_RED    = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_WALK   = 3'd3,
    S_NIGHT  = 3'd4
  } state_t;

  localparam logic [7:0] GREEN_L  = 8'(GREEN_S);
  localparam logic [7:0] YELLOW_L = 8'(YELLOW_S);
  localparam logic [7:0] RED_L    = 8'(RED_S);
  localparam logic [7:0] WALK_L   = 8'(WALK_S);
  localparam logic [7:0] CUT_L    = 8'(PED_CUT_S);

  // bit order: {night_mode, ped_req, clk_4hz, clk_1hz}
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [2:0] dly;
  logic       tick_1s;
  logic       tick_q;
  logic       ped_edge;
  logic       night_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      dly      <= '0;
      tick_1s  <= 1'b0;
      tick_q   <= 1'b0;
      ped_edge <= 1'b0;
    end else begin
      sync1    <= {night_mode, ped_req, clk_4hz, clk_1hz};
      sync2    <= sync1;
      dly      <= sync2[2:0];
      tick_1s  <= sync2[0] & ~dly[0];
      tick_q   <= sync2[1] & ~dly[1];
      ped_edge <= sync2[2] & ~dly[2];
    end
  end

  assign night_s = sync2[3];

  state_t     state;
  state_t     state_n;
  logic [7:0] sec;
  logic [7:0] sec_n;
  logic       ped;
  logic       ped_n;
  logic       blink;
  logic       blink_n;
  logic       red_n;
  logic       yellow_n;
  logic       green_n;
  logic       walk_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_RED;
      sec    <= RED_L;
      ped    <= 1'b0;
      blink  <= 1'b0;
      red    <= 1'b1;
      yellow <= 1'b0;
      green  <= 1'b0;
      walk   <= 1'b0;
    end else begin
      state  <= state_n;
      sec    <= sec_n;
      ped    <= ped_n;
      blink  <= blink_n;
      red    <= red_n;
      yellow <= yellow_n;
      green  <= green_n;
      walk   <= walk_n;
    end
  end

  always_comb begin
    state_n = state;
    sec_n   = sec;
    ped_n   = ped;
    blink_n = blink;
    if (night_s) begin
      state_n = S_NIGHT;
      sec_n   = 8'd0;
      ped_n   = 1'b0;
      blink_n = (state == S_NIGHT) ? (blink ^ tick_q) : 1'b1;
    end else if (state == S_NIGHT) begin
      blink_n = blink ^ tick_q;
      if (tick_1s) begin
        state_n = S_RED;
        sec_n   = RED_L;
      end
    end else begin
      if (ped_edge && state != S_WALK) ped_n = 1'b1;
      // a fresh request cuts green on the same edge it is latched
      if (state == S_GREEN && ped_n && sec > CUT_L) begin
        sec_n = CUT_L;
      end else if (tick_1s) begin
        if (sec > 8'd1) begin
          sec_n = sec - 8'd1;
        end else begin
          unique case (state)
            S_RED, S_WALK: begin
              state_n = S_GREEN;
              sec_n   = GREEN_L;
            end
            S_GREEN: begin
              state_n = S_YELLOW;
              sec_n   = YELLOW_L;
            end
            S_YELLOW: begin
              if (ped_n) begin
                state_n = S_WALK;
                sec_n   = WALK_L;
                ped_n   = 1'b0;
              end else begin
                state_n = S_RED;
                sec_n   = RED_L;
              end
            end
            default: begin
              state_n = S_RED;
              sec_n   = RED_L;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    red_n    = (state_n == S_RED) || (state_n == S_WALK);
    yellow_n = (state_n == S_YELLOW) || (state_n == S_NIGHT && blink_n);
    green_n  = (state_n == S_GREEN);
    walk_n   = (state_n == S_WALK);
  end

  assign phase       = state;
  assign sec_left    = sec;
  assign ped_pending = ped;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed scoreboard bench for traffic_light_ctrl.
// Expectations are queued with each step and popped when the DUT reaches it.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_1hz = 1'b0;
  logic       clk_4hz = 1'b0;
  logic       ped_req = 1'b0;
  logic       night_mode = 1'b0;
  logic       red;
  logic       yellow;
  logic       green;
  logic       walk;
  logic [2:0] phase;
  logic [7:0] sec_left;
  logic       ped_pending;

  traffic_light_ctrl dut (
    .clk(clk),
    .rst(rst),
    .clk_1hz(clk_1hz),
    .clk_4hz(clk_4hz),
    .ped_req(ped_req),
    .night_mode(night_mode),
    .red(red),
    .yellow(yellow),
    .green(green),
    .walk(walk),
    .phase(phase),
    .sec_left(sec_left),
    .ped_pending(ped_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #1;
    forever #1000 clk_1hz = ~clk_1hz;
  end

  initial begin
    #2;
    forever #250 clk_4hz = ~clk_4hz;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      tag;
    logic [2:0] ph;
    logic [7:0] sec;
    logic [3:0] lamps;
    logic       ped;
    int         dur;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;
  int t_last = 0;
  int t_tick = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [2:0] ph,
                      input logic [7:0] sec, input logic [3:0] lamps,
                      input logic ped, input int dur);
    exp_t e;
    e.tag = tag;
    e.ph = ph;
    e.sec = sec;
    e.lamps = lamps;
    e.ped = ped;
    e.dur = dur;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int dur);
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, " phase"}, 32'(phase), 32'(e.ph));
    chk({e.tag, " sec_left"}, 32'(sec_left), 32'(e.sec));
    chk({e.tag, " lamps"}, 32'({red, yellow, green, walk}), 32'(e.lamps));
    chk({e.tag, " ped_pending"}, 32'(ped_pending), 32'(e.ped));
    if (e.dur > 0) chk({e.tag, " cycles"}, 32'(dur), 32'(e.dur));
  endtask

  task automatic wait_change(input int budget);
    logic [2:0] p0;
    int n;
    p0 = phase;
    n = 0;
    while (phase === p0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("phase_change", 32'(phase !== p0), 32'd1);
    pop_check(cyc - t_last);
    t_last = cyc;
  endtask

  task automatic wait_state(input logic [2:0] ph, input logic [7:0] sec,
                            input int budget);
    int n;
    n = 0;
    while (!(phase === ph && sec_left === sec) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("reach_state", 32'(phase === ph && sec_left === sec), 32'd1);
  endtask

  task automatic wait_yellow(input int budget, output int t);
    logic y0;
    int n;
    y0 = yellow;
    n = 0;
    while (yellow === y0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("blink_toggle", 32'(yellow !== y0), 32'd1);
    t = cyc;
  endtask

  initial begin
    int n;
    int t1;
    int t2;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    push("reset", 3'd0, 8'd8, 4'b1000, 1'b0, 0);
    pop_check(0);
    rst = 1'b0;
    t_last = cyc;

    push("green1", 3'd1, 8'd10, 4'b0010, 1'b0, 0);
    wait_change(2600);
    push("yellow1", 3'd2, 8'd3, 4'b0100, 1'b0, 2000);
    wait_change(2600);
    push("red1", 3'd0, 8'd8, 4'b1000, 1'b0, 600);
    wait_change(2600);
    push("green2", 3'd1, 8'd10, 4'b0010, 1'b0, 1600);
    wait_change(2600);

    wait_state(3'd1, 8'd9, 400);
    ped_req = 1'b1;
    n = 0;
    while (!(ped_pending === 1'b1 && sec_left === 8'd4) && n < 4) begin
      @(negedge clk);
      n++;
    end
    ped_req = 1'b0;
    push("ped_cut", 3'd1, 8'd4, 4'b0010, 1'b1, 0);
    pop_check(0);
    push("yellow_ped", 3'd2, 8'd3, 4'b0100, 1'b1, 0);
    wait_change(1000);
    push("walk1", 3'd3, 8'd6, 4'b1001, 1'b0, 600);
    wait_change(800);
    push("green3", 3'd1, 8'd10, 4'b0010, 1'b0, 1200);
    wait_change(1400);

    wait_state(3'd1, 8'd2, 2000);
    ped_req = 1'b1;
    repeat (8) @(negedge clk);
    ped_req = 1'b0;
    push("late_req", 3'd1, 8'd2, 4'b0010, 1'b1, 0);
    pop_check(0);
    push("yellow_late", 3'd2, 8'd3, 4'b0100, 1'b1, 2000);
    wait_change(600);
    push("walk2", 3'd3, 8'd6, 4'b1001, 1'b0, 600);
    wait_change(800);

    repeat (20) @(negedge clk);
    ped_req = 1'b1;
    repeat (10) @(negedge clk);
    ped_req = 1'b0;
    repeat (5) @(negedge clk);
    push("walk_req", 3'd3, 8'd6, 4'b1001, 1'b0, 0);
    pop_check(0);
    push("green4", 3'd1, 8'd10, 4'b0010, 1'b0, 1200);
    wait_change(1400);
    push("yellow4", 3'd2, 8'd3, 4'b0100, 1'b0, 2000);
    wait_change(2200);
    push("red4", 3'd0, 8'd8, 4'b1000, 1'b0, 600);
    wait_change(800);
    push("green5", 3'd1, 8'd10, 4'b0010, 1'b0, 1600);
    wait_change(1800);
    t_tick = t_last;

    wait_state(3'd1, 8'd5, 2000);
    night_mode = 1'b1;
    n = 0;
    while (phase !== 3'd4 && n < 4) begin
      @(negedge clk);
      n++;
    end
    push("night", 3'd4, 8'd0, 4'b0100, 1'b0, 0);
    pop_check(0);
    t_last = cyc;
    wait_yellow(60, t1);
    wait_yellow(60, t2);
    chk("blink_period", 32'(t2 - t1), 32'd50);
    chk("night_sec_left", 32'(sec_left), 32'd0);

    n = 0;
    while (((cyc - t_tick) % 200) != 20 && n < 250) begin
      @(negedge clk);
      n++;
    end
    night_mode = 1'b0;
    repeat (30) @(negedge clk);
    night_mode = 1'b1;
    repeat (300) @(negedge clk);
    chk("night_hold", 32'(phase), 32'd4);

    night_mode = 1'b0;
    push("night_exit", 3'd0, 8'd8, 4'b1000, 1'b0, 0);
    wait_change(500);
    chk("exit_on_tick", 32'((t_last - t_tick) % 200), 32'd0);

    push("green6", 3'd1, 8'd10, 4'b0010, 1'b0, 1600);
    wait_change(1800);
    wait_state(3'd1, 8'd9, 400);
    ped_req = 1'b1;
    repeat (6) @(negedge clk);
    ped_req = 1'b0;
    push("yellow6", 3'd2, 8'd3, 4'b0100, 1'b1, 0);
    wait_change(1400);
    push("walk6", 3'd3, 8'd6, 4'b1001, 1'b0, 600);
    wait_change(800);

    repeat (50) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_before_edge", 32'(clk), 32'd0);
    push("async_rst", 3'd0, 8'd8, 4'b1000, 1'b0, 0);
    pop_check(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
